// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks destination registers of in-flight long-latency ops (variable
//   latency loads, mul/div) from issue in ID until their writeback, and
//   raises Stall for the ID stage on load-use, RAW-on-pending, WAW-on-pending
//   and capacity conflicts.
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   ID_*              : decoded fields of the instruction currently in ID
//   EX_MemRead, EX_Rd : load in EX and its destination (load-use check)
//   Flush             : ID instruction is being discarded this cycle
//   WB_Done, WB_DoneRd: long op completing this cycle and its register
//   Stall             : hold PC/IF-ID, insert ID/EX bubble (combinational)
//   Pending           : per-register pending-write bits, bit 0 always 0
//   OutstandingCount  : population count of Pending
//   Full              : OutstandingCount == MAX_OUTSTANDING (registered)
//   ErrSpurious       : sticky, a completion hit x0 or a non-pending register
module hazard_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_Valid,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic             ID_UsesRs1,
  input  logic             ID_UsesRs2,
  input  logic [4:0]       ID_Rd,
  input  logic             ID_RegWrite,
  input  logic             ID_LongOp,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rd,
  input  logic             Flush,
  input  logic             WB_Done,
  input  logic [4:0]       WB_DoneRd,
  output logic             Stall,
  output logic [31:0]      Pending,
  output logic [CNT_W-1:0] OutstandingCount,
  output logic             Full,
  output logic             ErrSpurious
);

  logic [31:0]      pending_q;
  logic [CNT_W-1:0] count_q;
  logic             full_q;
  logic             err_q;

  logic             load_use;
  logic             raw_hit;
  logic             waw_hit;
  logic             cap_hit;
  logic             issue;
  logic             done;
  logic             spurious;
  logic [31:0]      pending_nxt;
  logic [CNT_W-1:0] count_nxt;

  // Hazard detection: uses only registered Pending/Full, so a completion
  // in this cycle releases its dependants one cycle later.
  always_comb begin
    load_use = EX_MemRead && (EX_Rd != 5'd0) &&
               ((ID_UsesRs1 && (EX_Rd == ID_Rs1)) ||
                (ID_UsesRs2 && (EX_Rd == ID_Rs2)));
    raw_hit  = (ID_UsesRs1 && pending_q[ID_Rs1]) ||
               (ID_UsesRs2 && pending_q[ID_Rs2]);
    waw_hit  = ID_RegWrite && pending_q[ID_Rd];
    cap_hit  = ID_LongOp && ID_RegWrite && (ID_Rd != 5'd0) && full_q;
    Stall    = ID_Valid && (load_use || raw_hit || waw_hit || cap_hit);
  end

  // Issue/complete events. Issue and done never name the same register:
  // a pending Rd always stalls via the WAW check.
  always_comb begin
    issue    = ID_Valid && !Stall && !Flush && ID_LongOp && ID_RegWrite &&
               (ID_Rd != 5'd0);
    done     = WB_Done && (WB_DoneRd != 5'd0) && pending_q[WB_DoneRd];
    spurious = WB_Done && !done;

    pending_nxt = pending_q;
    if (issue) pending_nxt[ID_Rd] = 1'b1;
    if (done)  pending_nxt[WB_DoneRd] = 1'b0;
    pending_nxt[0] = 1'b0;

    count_nxt = count_q + CNT_W'(issue) - CNT_W'(done);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_nxt;
      count_q   <= count_nxt;
      full_q    <= (count_nxt == CNT_W'(MAX_OUTSTANDING));
      if (spurious) err_q <= 1'b1;
    end
  end

  assign Pending          = pending_q;
  assign OutstandingCount = count_q;
  assign Full             = full_q;
  assign ErrSpurious      = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ID_Valid, ID_UsesRs1, ID_UsesRs2, ID_RegWrite, ID_LongOp;
  logic [4:0]  ID_Rs1, ID_Rs2, ID_Rd, EX_Rd, WB_DoneRd;
  logic        EX_MemRead, Flush, WB_Done;
  logic        Stall, Full, ErrSpurious;
  logic [31:0] Pending;
  logic [2:0]  OutstandingCount;

  hazard_scoreboard #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Valid(ID_Valid), .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2),
    .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
    .ID_Rd(ID_Rd), .ID_RegWrite(ID_RegWrite), .ID_LongOp(ID_LongOp),
    .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd), .Flush(Flush),
    .WB_Done(WB_Done), .WB_DoneRd(WB_DoneRd),
    .Stall(Stall), .Pending(Pending), .OutstandingCount(OutstandingCount),
    .Full(Full), .ErrSpurious(ErrSpurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          step;
    logic        stall;
    logic [31:0] pend;
    logic [2:0]  cnt;
    logic        full;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  task automatic chk(input string nm, input int st, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d actual 0x%0h required 0x%0h", nm, st, act, req);
    end
  endtask

  // Monitor: the DUT presents a full state/stall snapshot every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall", e.step, {31'd0, Stall}, {31'd0, e.stall});
      chk("pending", e.step, Pending, e.pend);
      chk("count", e.step, {29'd0, OutstandingCount}, {29'd0, e.cnt});
      chk("full", e.step, {31'd0, Full}, {31'd0, e.full});
      chk("err", e.step, {31'd0, ErrSpurious}, {31'd0, e.err});
    end
  end

  // Advance to just after the next rising edge and idle all ID/EX/WB inputs.
  task automatic nxt();
    @(posedge clk);
    #1;
    ID_Valid = 0; ID_UsesRs1 = 0; ID_UsesRs2 = 0; ID_RegWrite = 0;
    ID_LongOp = 0; ID_Rs1 = 0; ID_Rs2 = 0; ID_Rd = 0;
    EX_MemRead = 0; EX_Rd = 0; Flush = 0; WB_Done = 0; WB_DoneRd = 0;
    step_no++;
  endtask

  task automatic expect_cyc(input logic st, input logic [31:0] p,
                            input logic [2:0] c, input logic f, input logic e);
    exp_t x;
    x.step = step_no; x.stall = st; x.pend = p; x.cnt = c; x.full = f; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic long_op(input logic [4:0] rd);
    ID_Valid = 1; ID_LongOp = 1; ID_RegWrite = 1; ID_Rd = rd;
  endtask

  task automatic wb(input logic [4:0] rd);
    WB_Done = 1; WB_DoneRd = rd;
  endtask

  initial begin
    rst_n = 0;
    nxt(); expect_cyc(0, 32'h0, 0, 0, 0);                  // in reset
    nxt(); rst_n = 1; long_op(5); expect_cyc(0, 32'h0, 0, 0, 0);
    nxt(); expect_cyc(0, 32'h20, 1, 0, 0);
    // RAW on pending x5, released one cycle after WB_Done
    nxt(); ID_Valid = 1; ID_UsesRs1 = 1; ID_Rs1 = 5; expect_cyc(1, 32'h20, 1, 0, 0);
    nxt(); ID_Valid = 1; ID_UsesRs1 = 1; ID_Rs1 = 5; wb(5); expect_cyc(1, 32'h20, 1, 0, 0);
    nxt(); ID_Valid = 1; ID_UsesRs1 = 1; ID_Rs1 = 5; expect_cyc(0, 32'h0, 0, 0, 0);
    // load-use, then x0 never matches
    nxt(); ID_Valid = 1; ID_UsesRs2 = 1; ID_Rs2 = 7; EX_MemRead = 1; EX_Rd = 7;
    expect_cyc(1, 32'h0, 0, 0, 0);
    nxt(); ID_Valid = 1; ID_UsesRs2 = 1; ID_Rs2 = 0; EX_MemRead = 1; EX_Rd = 0;
    expect_cyc(0, 32'h0, 0, 0, 0);
    // ID_Valid low masks a would-be load-use
    nxt(); ID_UsesRs2 = 1; ID_Rs2 = 7; EX_MemRead = 1; EX_Rd = 7;
    expect_cyc(0, 32'h0, 0, 0, 0);
    // fill to capacity
    nxt(); long_op(1); expect_cyc(0, 32'h0, 0, 0, 0);
    nxt(); long_op(2); expect_cyc(0, 32'h2, 1, 0, 0);
    nxt(); long_op(3); expect_cyc(0, 32'h6, 2, 0, 0);
    nxt(); long_op(4); expect_cyc(0, 32'hE, 3, 0, 0);
    nxt(); long_op(6); expect_cyc(1, 32'h1E, 4, 1, 0);
    nxt(); long_op(6); wb(2); expect_cyc(1, 32'h1E, 4, 1, 0);
    nxt(); long_op(6); expect_cyc(0, 32'h1A, 3, 0, 0);
    nxt(); expect_cyc(0, 32'h5A, 4, 1, 0);
    // drain x1, x4 leaving x3, x6 (count 2)
    nxt(); wb(1); expect_cyc(0, 32'h5A, 4, 1, 0);
    nxt(); wb(4); expect_cyc(0, 32'h58, 3, 0, 0);
    // simultaneous issue x8 and done x3
    nxt(); long_op(8); wb(3); expect_cyc(0, 32'h48, 2, 0, 0);
    nxt(); expect_cyc(0, 32'h140, 2, 0, 0);
    // WAW: plain write to pending x6
    nxt(); ID_Valid = 1; ID_RegWrite = 1; ID_Rd = 6; expect_cyc(1, 32'h140, 2, 0, 0);
    nxt(); wb(6); expect_cyc(0, 32'h140, 2, 0, 0);
    nxt(); wb(8); expect_cyc(0, 32'h100, 1, 0, 0);
    nxt(); expect_cyc(0, 32'h0, 0, 0, 0);
    // flushed long op does not issue; its completion is spurious
    nxt(); long_op(9); Flush = 1; expect_cyc(0, 32'h0, 0, 0, 0);
    nxt(); wb(9); expect_cyc(0, 32'h0, 0, 0, 0);
    nxt(); expect_cyc(0, 32'h0, 0, 0, 1);
    nxt(); wb(0); expect_cyc(0, 32'h0, 0, 0, 1);
    // mid-operation async reset
    nxt(); long_op(10); expect_cyc(0, 32'h0, 0, 0, 1);
    nxt(); expect_cyc(0, 32'h400, 1, 0, 1);
    nxt(); rst_n = 0; expect_cyc(0, 32'h0, 0, 0, 0);
    nxt(); rst_n = 1; wb(10); expect_cyc(0, 32'h0, 0, 0, 0);
    nxt(); expect_cyc(0, 32'h0, 0, 0, 1);
    nxt();
    repeat (3) @(posedge clk);
    chk("queue_drained", step_no, exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side tracking for register hazards.
- Records destination registers of in-flight long-latency ops (variable-latency loads, mul/div) from issue until they complete.
- Raises Stall in ID when an operand or destination conflicts with a pending write that EX/MEM/WB bypassing cannot cover.
- Also covers the classic load-use case, EX_MemRead with a matching EX_Rd.
- Sits beside the ID stage; drives the PC/IF-ID hold and ID/EX bubble insertion.

Parameters:
MAX_OUTSTANDING, 4, max simultaneously pending long-op writes (1..31)
CNT_W, $clog2(MAX_OUTSTANDING+1), width of OutstandingCount (derived, not overridden)

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
ID_Valid  input  1  ID holds a real instruction
ID_Rs1  input  5  source register 1
ID_Rs2  input  5  source register 2
ID_UsesRs1  input  1  instruction reads Rs1
ID_UsesRs2  input  1  instruction reads Rs2
ID_Rd  input  5  destination register
ID_RegWrite  input  1  instruction writes Rd
ID_LongOp  input  1  instruction is long-latency (completes via WB_Done)
EX_MemRead  input  1  EX-stage instruction is a load
EX_Rd  input  5  EX-stage destination
Flush  input  1  branch/exception flush; ID instruction is discarded
WB_Done  input  1  a long op writes the regfile this cycle
WB_DoneRd  input  5  register written by completing long op
Stall  output  1  hold IF/ID, bubble ID/EX (combinational)
Pending  output  32  per-register pending bit; bit 0 always 0
OutstandingCount  output  CNT_W  number of set Pending bits
Full  output  1  OutstandingCount == MAX_OUTSTANDING (registered)
ErrSpurious  output  1  sticky: WB_Done hit a non-pending or x0 register

Behaviour:
- Reset (rst_n low, async): Pending=0, OutstandingCount=0, Full=0, ErrSpurious=0. Stall is then a pure function of the inputs and cleared state.
- Stall is combinational and is 0 when ID_Valid=0. Otherwise Stall=1 if any of these holds:
  - Load-use: EX_MemRead & EX_Rd!=0 & ((ID_UsesRs1 & EX_Rd==ID_Rs1) | (ID_UsesRs2 & EX_Rd==ID_Rs2)).
  - RAW on long op: (ID_UsesRs1 & Pending[ID_Rs1]) | (ID_UsesRs2 & Pending[ID_Rs2]).
  - WAW: ID_RegWrite & Pending[ID_Rd].
  - Capacity: ID_LongOp & ID_RegWrite & ID_Rd!=0 & Full.
- Stall uses registered Pending/Full only. There is no bypass of a same-cycle WB_Done, so a completion releases a dependent instruction one cycle later.
- Issue event = ID_Valid & ~Stall & ~Flush & ID_LongOp & ID_RegWrite & ID_Rd!=0. On the next edge, Pending[ID_Rd] is set.
- Done event = WB_Done & WB_DoneRd!=0 & Pending[WB_DoneRd]. On the next edge, Pending[WB_DoneRd] is cleared.
- WB_Done with Rd=0 or a non-pending Rd: no state change; ErrSpurious is set and stays set until reset.
- OutstandingCount next = count + issue - done. Simultaneous issue and done leaves the count unchanged.
  - Issue and done cannot target the same register: a pending Rd forces Stall through the WAW check.
- Full is recomputed from the next count each edge. Done while Full does not permit an issue in the same cycle; the issue proceeds the following cycle.
- Flush suppresses issue only. Already-pending bits are not cleared, because issued long ops still complete.
- Stall asserted together with Flush has no side effect on state.
- Counter never wraps: issue is impossible when Full, and done is impossible when the count is 0 (no pending bits).
- Mid-operation async reset clears everything immediately. Later WB_Done pulses for lost ops set ErrSpurious.

Test Plan:
- Reset, then long op Rd=5 issued (ID_LongOp=1, ID_RegWrite=1) -> next cycle Pending=0x20, OutstandingCount=1, Stall=0 on the issuing cycle.
- Long op x5 pending; ID reads Rs1=5 -> Stall=1 every cycle. WB_Done Rd=5 -> Stall still 1 that cycle, 0 the next; Pending=0.
- EX_MemRead=1, EX_Rd=7, ID_UsesRs2=1, Rs2=7 -> Stall=1 one cycle. Rs2=0 with EX_Rd=0 -> Stall=0.
- MAX_OUTSTANDING=4: issue to x1..x4 -> Full=1. Fifth long op to x6 -> Stall=1. WB_Done x2 -> Full=0 next cycle; x6 issues the cycle after, count back to 4.
- Same cycle: issue x8 and WB_Done x3 (x3 pending, count 2) -> count stays 2, Pending gains bit 8 and loses bit 3.
- Flush=1 with an unstalled long op to x9 -> Pending[9] stays 0. Then WB_Done Rd=9 -> ErrSpurious=1, persisting until rst_n=0.
